audio_ice40_fc_argmax: RTL and testbench
========================================

// Module: audio_ice40_fc_argmax
// PURPOSE
// - Downstream drain stage of the FC execution-unit (EU) cascade chain. After each FC pass, shifts the
//   N_EU ReLU'd 16-bit outputs out of the chain tail, streams them out, and tracks the running argmax.
// - Supports multi-pass layers (classes > N_EU); after the last pass, reports keyword class, score and detect flag.
// PARAMETERS
// - N_EU    8   number of EUs in the cascade chain = entries drained per pass
// - MAX_CLS 32  max classes per inference; CLS_W = $clog2(MAX_CLS)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - i_start      in   1      pulse: chain outputs are final (EU run has fallen), begin drain of one pass
// - i_first      in   1      qualifies i_start: first pass of inference (clear pass count and best)
// - i_last       in   1      qualifies i_start: final pass (produce result at end of drain)
// - i_num_cls    in   CLS_W  total classes in inference; entries with index >= i_num_cls are drained but ignored
// - i_threshold  in   16     detect threshold (unsigned, same 5.10/1.7 scale as EU output)
// - i_tail       in   16     cascade output of the tail EU (unsigned after ReLU)
// - o_shift      out  1      drives i_shift of every EU in the chain
// - o_busy       out  1      high from accepted i_start until drain (and result, on last pass) completes
// - o_val        out  1      strobe: o_data/o_idx valid (one per valid class entry)
// - o_data       out  16     drained EU value
// - o_idx        out  CLS_W  class index of o_data
// - o_done       out  1      one-cycle pulse: o_class/o_score/o_detect updated
// - o_class      out  CLS_W  argmax class index (held until next o_done)
// - o_score      out  16     value at argmax
// - o_detect     out  1      o_score >= i_threshold
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; pass count 0; best score 0, best index 0.
// - Chain order: first sampled tail entry is class base+0, k-th is base+k; base = pass_cnt*N_EU.
// - FSM IDLE -> DRAIN -> (RESULT if last) -> IDLE.
//   IDLE: i_start accepted only here; i_first/i_last/i_num_cls/i_threshold latched on acceptance.
//     If i_first: pass_cnt <= 0, best_score <= 0, best_idx <= 0. o_busy asserts the next cycle.
//   DRAIN: for k = 0..N_EU-1 (one entry per cycle), sample i_tail and assert o_shift the same cycle,
//     so the next entry is at i_tail the following cycle. Exactly N_EU o_shift pulses per pass.
//     If base+k < num_cls: o_val=1, o_data=i_tail, o_idx=base+k, registered (1-cycle latency after sample).
//     Argmax update: replace only if i_tail > best_score (strict), ties keep lowest index.
//     After k = N_EU-1: pass_cnt++; go to RESULT if last else IDLE (o_busy drops).
//   RESULT: one cycle; o_class<=best_idx, o_score<=best_score, o_detect<=(best_score>=thr), o_done=1.
// - Initial best_score 0 and best_idx 0: all-zero (all ReLU-clamped) outputs give class 0, score 0.
// - i_start while busy: ignored (no queue). i_start without i_first on pass 0 after reset: base 0.
// - pass_cnt saturates so base+k never wraps CLS_W: entries with base+k >= MAX_CLS treated as invalid.
// - reset mid-DRAIN: abort immediately, o_shift low next cycle; the chain is not drained (next EU run
//   rewrites it), no o_done.
// - o_val compare and argmax use the final sampled value; o_val, o_done never assert in the same cycle.
// STRUCTURE
// - Shared package audio_ice40_pkg: EU data width (16), MAX_CLS/CLS_W, FSM state encoding
//   (IDLE, DRAIN, RESULT).
// - Single module; one natural sub-module: audio_ice40_argmax_cmp (registered running max, strict
//   greater-than, clear/enable ports), reusable for other classification heads.
// TESTING
// - Reset, 1 pass, N_EU=8, num_cls=8, tail sequence 3,9,2,9,0,1,7,4 -> 8 o_shift, o_val x8 idx 0..7,
//   o_done, o_class=1 (tie kept lowest), o_score=9.
// - 3 passes (first, -, last), num_cls=20, max 0x1234 at class 17 -> o_val only for idx 0..19,
//   24 shifts total, o_class=17.
// - Threshold: score 0x0400 with thr 0x0400 -> o_detect=1; thr 0x0401 -> o_detect=0.
// - All-zero chain -> o_class=0, o_score=0, o_detect=(thr==0).
// - i_start pulsed during DRAIN -> ignored, shift count stays N_EU; reset asserted at k=3 -> o_shift,
//   o_busy, o_val low next cycle, no o_done; next i_first pass behaves as fresh inference.

Source files
------------

// File: rtl/audio_ice40_pkg.sv
// rtl/audio_ice40_pkg.sv - shared constants, types and FSM encoding for the audio FC head
package audio_ice40_pkg;

  localparam int DATA_W   = 16;
  localparam int N_EU     = 8;
  localparam int MAX_CLS  = 32;
  localparam int CLS_W    = $clog2(MAX_CLS);
  localparam int K_W      = $clog2(N_EU);
  localparam int MAX_PASS = MAX_CLS / N_EU;
  localparam int PASS_W   = $clog2(MAX_PASS + 1);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CLS_W-1:0]  cls_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  // One extra bit so a saturated pass count cannot wrap back onto a real class.
  function automatic logic [CLS_W:0] class_index(input logic [PASS_W-1:0] pass,
                                                 input logic [K_W-1:0]    k);
    return (CLS_W+1)'(pass) * (CLS_W+1)'(N_EU) + (CLS_W+1)'(k);
  endfunction

endpackage

// File: rtl/audio_ice40_fc_argmax_if.sv
// rtl/audio_ice40_fc_argmax_if.sv - control, chain-tail and result bundle of the FC drain stage
interface audio_ice40_fc_argmax_if;
  import audio_ice40_pkg::*;

  logic  i_start;
  logic  i_first;
  logic  i_last;
  cls_t  i_num_cls;
  data_t i_threshold;
  data_t i_tail;
  logic  o_shift;
  logic  o_busy;
  logic  o_val;
  data_t o_data;
  cls_t  o_idx;
  logic  o_done;
  cls_t  o_class;
  data_t o_score;
  logic  o_detect;

  modport master (
    output i_start, i_first, i_last, i_num_cls, i_threshold, i_tail,
    input  o_shift, o_busy, o_val, o_data, o_idx, o_done, o_class, o_score, o_detect
  );

  modport slave (
    input  i_start, i_first, i_last, i_num_cls, i_threshold, i_tail,
    output o_shift, o_busy, o_val, o_data, o_idx, o_done, o_class, o_score, o_detect
  );

endinterface

// File: rtl/audio_ice40_argmax_cmp.sv
// rtl/audio_ice40_argmax_cmp.sv - registered running maximum; strict greater-than keeps the earliest index on ties
module audio_ice40_argmax_cmp #(
  parameter int DW = 16,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [DW-1:0] value_i,
  input  logic [IW-1:0] index_i,
  output logic [DW-1:0] best_value_o,
  output logic [IW-1:0] best_index_o
);

  logic [DW-1:0] best_value_q;
  logic [IW-1:0] best_index_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      best_value_q <= '0;
      best_index_q <= '0;
    end else if (en_i && (value_i > best_value_q)) begin
      best_value_q <= value_i;
      best_index_q <= index_i;
    end
  end

  assign best_value_o = best_value_q;
  assign best_index_o = best_index_q;

endmodule

// File: rtl/audio_ice40_fc_argmax.sv
// rtl/audio_ice40_fc_argmax.sv - drains the FC EU cascade after each pass, streams entries and reports the argmax class
module audio_ice40_fc_argmax
  import audio_ice40_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  audio_ice40_fc_argmax_if.slave  bus
);

  state_e            state_q;
  logic [K_W-1:0]    k_q;
  logic [PASS_W-1:0] pass_q;
  logic              last_q;
  cls_t              num_cls_q;
  data_t             thr_q;
  logic              shift_q;
  logic              busy_q;
  logic              val_q;
  data_t             data_q;
  cls_t              idx_q;
  logic              done_q;
  cls_t              class_q;
  data_t             score_q;
  logic              detect_q;

  logic [CLS_W:0]    idx_full;
  logic              entry_ok;
  logic              accept;
  data_t             best_score;
  cls_t              best_idx;

  assign idx_full = class_index(pass_q, k_q);
  // Entries past the class count (or past the class space once pass_q saturates) are shifted out silently.
  assign entry_ok = (idx_full < (CLS_W+1)'(MAX_CLS)) && (idx_full < {1'b0, num_cls_q});
  assign accept   = (state_q == ST_IDLE) && bus.i_start;

  audio_ice40_argmax_cmp #(
    .DW(DATA_W),
    .IW(CLS_W)
  ) u_cmp (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (accept && bus.i_first),
    .en_i         ((state_q == ST_DRAIN) && entry_ok),
    .value_i      (bus.i_tail),
    .index_i      (idx_full[CLS_W-1:0]),
    .best_value_o (best_score),
    .best_index_o (best_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      pass_q    <= '0;
      last_q    <= 1'b0;
      num_cls_q <= '0;
      thr_q     <= '0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      val_q     <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      class_q   <= '0;
      score_q   <= '0;
      detect_q  <= 1'b0;
    end else begin
      val_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_q   <= ST_DRAIN;
            k_q       <= '0;
            shift_q   <= 1'b1;
            busy_q    <= 1'b1;
            last_q    <= bus.i_last;
            num_cls_q <= bus.i_num_cls;
            thr_q     <= bus.i_threshold;
            if (bus.i_first) pass_q <= '0;
          end
        end
        ST_DRAIN: begin
          // The chain advances on the same edge that samples it, so o_shift stays high for the whole drain.
          val_q <= entry_ok;
          if (entry_ok) begin
            data_q <= bus.i_tail;
            idx_q  <= idx_full[CLS_W-1:0];
          end
          if (k_q == K_W'(N_EU - 1)) begin
            shift_q <= 1'b0;
            if (pass_q != PASS_W'(MAX_PASS)) pass_q <= pass_q + 1'b1;
            if (last_q) begin
              state_q <= ST_RESULT;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_RESULT: begin
          class_q  <= best_idx;
          score_q  <= best_score;
          detect_q <= (best_score >= thr_q);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_shift  = shift_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_val    = val_q;
  assign bus.o_data   = data_q;
  assign bus.o_idx    = idx_q;
  assign bus.o_done   = done_q;
  assign bus.o_class  = class_q;
  assign bus.o_score  = score_q;
  assign bus.o_detect = detect_q;

endmodule

// File: tb/tb_audio_ice40_fc_argmax.sv
// tb/tb_audio_ice40_fc_argmax.sv - directed and randomized bench for the FC drain/argmax stage
module tb_audio_ice40_fc_argmax;
  import audio_ice40_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_ice40_fc_argmax_if bus ();

  audio_ice40_fc_argmax dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  data_t chain[N_EU];
  data_t all_vals[64];
  int    tidx = 0;
  bit    shift_prev = 1'b0;
  int    shift_cnt, done_cnt;
  int    val_idx_q[$];
  int    val_data_q[$];
  bit    overlap;
  logic [31:0] done_class, done_score, done_detect;

  // Chain model and output monitor: the tail advances one entry after every cycle with o_shift high.
  always @(negedge clk) begin
    if (shift_prev) tidx++;
    bus.i_tail = (tidx < N_EU) ? chain[tidx] : '0;
    shift_prev = bus.o_shift;
    if (bus.o_shift) shift_cnt++;
    if (bus.o_val) begin
      val_idx_q.push_back(int'(bus.o_idx));
      val_data_q.push_back(int'(bus.o_data));
    end
    if (bus.o_done) begin
      done_cnt++;
      done_class  = 32'(bus.o_class);
      done_score  = 32'(bus.o_score);
      done_detect = 32'(bus.o_detect);
    end
    if (bus.o_val && bus.o_done) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    shift_cnt = 0;
    done_cnt  = 0;
    overlap   = 1'b0;
    val_idx_q.delete();
    val_data_q.delete();
  endtask

  // Runs an inference of npass passes over all_vals and checks stream, shifts and result against the model.
  task automatic run_inf(input string tag, input int ncls, input int npass, input data_t thr, input int poke);
    int exp_idx[$];
    int exp_data[$];
    int m, bi, c;
    clear_mon();
    for (int g = 0; g < npass * N_EU; g++) begin
      if (g < ncls && g < MAX_CLS) begin
        exp_idx.push_back(g);
        exp_data.push_back(int'(all_vals[g]));
      end
    end
    m = 0;
    foreach (exp_data[i]) if (exp_data[i] > m) m = exp_data[i];
    bi = 0;
    if (m > 0) begin
      for (int i = exp_data.size() - 1; i >= 0; i--) if (exp_data[i] == m) bi = exp_idx[i];
    end

    for (int p = 0; p < npass; p++) begin
      for (int k = 0; k < N_EU; k++) chain[k] = all_vals[p * N_EU + k];
      tidx = 0;
      bus.i_start     = 1'b1;
      bus.i_first     = (p == 0);
      bus.i_last      = (p == npass - 1);
      bus.i_num_cls   = cls_t'(ncls);
      bus.i_threshold = thr;
      tick();
      bus.i_start = 1'b0;
      if (p == 0) chk($sformatf("%s busy_after_start", tag), 32'(bus.o_busy), 32'd1);
      c = 0;
      while (bus.o_busy && c < 200) begin
        if (c == poke) begin
          bus.i_start   = 1'b1;
          bus.i_first   = 1'b1;
          bus.i_num_cls = cls_t'(3);
        end else begin
          bus.i_start = 1'b0;
        end
        tick();
        c++;
      end
      bus.i_start = 1'b0;
      chk($sformatf("%s pass%0d busy_timeout", tag, p), 32'(bus.o_busy), 32'd0);
    end
    tick();
    tick();

    chk($sformatf("%s shifts", tag), 32'(shift_cnt), 32'(npass * N_EU));
    chk($sformatf("%s val_count", tag), 32'(val_idx_q.size()), 32'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < val_idx_q.size(); i++) begin
      chk($sformatf("%s idx[%0d]", tag, i), 32'(val_idx_q[i]), 32'(exp_idx[i]));
      chk($sformatf("%s data[%0d]", tag, i), 32'(val_data_q[i]), 32'(exp_data[i]));
    end
    chk($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s class", tag), done_class, 32'(bi));
    chk($sformatf("%s score", tag), done_score, 32'(m));
    chk($sformatf("%s detect", tag), done_detect, 32'(m >= int'(thr)));
    chk($sformatf("%s val_done_overlap", tag), 32'(overlap), 32'd0);
  endtask

  initial begin
    int ncls, npass;
    data_t thr;
    data_t tb_vals [N_EU];

    reset           = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_first     = 1'b0;
    bus.i_last      = 1'b0;
    bus.i_num_cls   = '0;
    bus.i_threshold = '0;
    bus.i_tail      = '0;
    foreach (chain[k]) chain[k] = '0;
    foreach (all_vals[g]) all_vals[g] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("reset shift",  32'(bus.o_shift),  32'd0);
    chk("reset busy",   32'(bus.o_busy),   32'd0);
    chk("reset val",    32'(bus.o_val),    32'd0);
    chk("reset data",   32'(bus.o_data),   32'd0);
    chk("reset idx",    32'(bus.o_idx),    32'd0);
    chk("reset done",   32'(bus.o_done),   32'd0);
    chk("reset class",  32'(bus.o_class),  32'd0);
    chk("reset score",  32'(bus.o_score),  32'd0);
    chk("reset detect", 32'(bus.o_detect), 32'd0);

    tb_vals = '{16'd3, 16'd9, 16'd2, 16'd9, 16'd0, 16'd1, 16'd7, 16'd4};
    foreach (tb_vals[k]) all_vals[k] = tb_vals[k];
    run_inf("single", 8, 1, 16'd9, -1);
    chk("single class_is_1", done_class, 32'd1);
    chk("single score_is_9", done_score, 32'd9);

    for (int g = 0; g < 24; g++) all_vals[g] = data_t'($urandom_range(0, 16'h1233));
    for (int g = 20; g < 24; g++) all_vals[g] = 16'hFFFF;
    all_vals[17] = 16'h1234;
    run_inf("multi", 20, 3, 16'h1000, -1);
    chk("multi class_is_17", done_class, 32'd17);

    foreach (all_vals[g]) all_vals[g] = '0;
    all_vals[2] = 16'h0400;
    run_inf("thr_eq", 8, 1, 16'h0400, -1);
    chk("thr_eq detect_1", done_detect, 32'd1);
    run_inf("thr_gt", 8, 1, 16'h0401, -1);
    chk("thr_gt detect_0", done_detect, 32'd0);

    foreach (all_vals[g]) all_vals[g] = '0;
    run_inf("zero_thr0", 8, 1, 16'h0000, -1);
    run_inf("zero_thr5", 8, 1, 16'h0005, -1);

    for (int g = 0; g < 8; g++) all_vals[g] = data_t'($urandom_range(1, 500));
    run_inf("start_in_drain", 8, 1, 16'd100, 2);

    for (int g = 0; g < 40; g++) all_vals[g] = data_t'($urandom_range(0, 16'hFFFF));
    run_inf("saturate", 31, 5, 16'h8000, -1);

    clear_mon();
    for (int k = 0; k < N_EU; k++) chain[k] = 16'hBEEF;
    tidx = 0;
    bus.i_start     = 1'b1;
    bus.i_first     = 1'b1;
    bus.i_last      = 1'b1;
    bus.i_num_cls   = cls_t'(8);
    bus.i_threshold = '0;
    tick();
    bus.i_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort shift", 32'(bus.o_shift), 32'd0);
    chk("abort busy",  32'(bus.o_busy),  32'd0);
    chk("abort val",   32'(bus.o_val),   32'd0);
    repeat (12) tick();
    chk("abort no_done", 32'(done_cnt), 32'd0);

    for (int g = 0; g < 16; g++) all_vals[g] = data_t'($urandom_range(0, 300));
    run_inf("after_abort", 12, 2, 16'd150, -1);

    for (int it = 0; it < 8; it++) begin
      ncls  = $urandom_range(1, 31);
      npass = (ncls + N_EU - 1) / N_EU;
      thr   = data_t'($urandom_range(0, 15));
      for (int g = 0; g < 40; g++) begin
        if (it[0]) all_vals[g] = data_t'($urandom_range(0, 15));
        else       all_vals[g] = data_t'($urandom_range(0, 16'hFFFF));
      end
      run_inf($sformatf("rand%0d", it), ncls, npass, thr, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
